// File: rtl/operand_fwd_mux.sv
// operand_fwd_mux: resolves source operands from the EX/MEM/WB bypass network and holds them for EX.
// Forwarding is enabled by defining OPERAND_FWD_EN; without it every in-flight write match stalls.
module operand_fwd_mux #(
  parameter int DW      = 32,
  parameter int NUM_OPS = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  output logic                  id_ready,
  input  logic [NUM_OPS*5-1:0]  id_rs,
  input  logic [NUM_OPS*DW-1:0] id_rf_data,
  input  logic                  ex_wr,
  input  logic                  mem_wr,
  input  logic                  wb_wr,
  input  logic [4:0]            ex_rd,
  input  logic [4:0]            mem_rd,
  input  logic [4:0]            wb_rd,
  input  logic [DW-1:0]         ex_data,
  input  logic [DW-1:0]         mem_data,
  input  logic [DW-1:0]         wb_data,
  input  logic                  ex_is_load,
  input  logic                  ex_ready,
  input  logic                  flush,
  output logic                  out_valid,
  output logic [NUM_OPS*DW-1:0] out_ops,
  output logic                  stall,
  output logic [1:0]            stall_cnt
);
  typedef enum logic {RUN, STALL} state_t;
  state_t state, state_n;
  logic [NUM_OPS*DW-1:0] res;
  logic [NUM_OPS-1:0] haz;
  logic [1:0] cnt_n;
  genvar i;
  for (i = 0; i < NUM_OPS; i++) begin : g_op
    logic [4:0] rs;
    logic ex_m, mem_m, wb_m;
    assign rs    = id_rs[5*i +: 5];
    assign ex_m  = ex_wr && ex_rd == rs;
    assign mem_m = mem_wr && mem_rd == rs;
    assign wb_m  = wb_wr && wb_rd == rs;
`ifdef OPERAND_FWD_EN
    // A load in EX has no data yet, so it is skipped here and stalls instead.
    assign res[DW*i +: DW] = rs == 5'd0 ? '0 :
                             ex_m && !ex_is_load ? ex_data :
                             mem_m ? mem_data :
                             wb_m ? wb_data : id_rf_data[DW*i +: DW];
    assign haz[i] = rs != 5'd0 && ex_m && ex_is_load;
`else
    assign res[DW*i +: DW] = rs == 5'd0 ? '0 : id_rf_data[DW*i +: DW];
    assign haz[i] = rs != 5'd0 && (ex_m || mem_m || wb_m);
`endif
  end
`ifndef OPERAND_FWD_EN
  logic unused_fwd;
  assign unused_fwd = ^{ex_data, mem_data, wb_data, ex_is_load};
`endif
  assign stall    = id_valid && |haz;
  assign id_ready = !rst && !stall && (ex_ready || !out_valid);
  always_comb begin
    state_n = stall && !flush ? STALL : RUN;
    cnt_n   = state_n == RUN ? 2'd0 : state == RUN ? 2'd1 :
              stall_cnt == 2'd3 ? 2'd3 : stall_cnt + 2'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      stall_cnt <= 2'd0;
      out_valid <= 1'b0;
      out_ops   <= '0;
    end else begin
      state     <= state_n;
      stall_cnt <= cnt_n;
      if (flush) out_valid <= 1'b0;
      else if (id_valid && id_ready) begin
        out_valid <= 1'b1;
        out_ops   <= res;
      end else if (ex_ready) out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_operand_fwd_mux.sv
// tb_operand_fwd_mux: directed checks of operand resolution, stall FSM, backpressure, flush and reset.
module tb_operand_fwd_mux;
  logic        clk = 1'b0;
  logic        rst, id_valid, id_ready;
  logic [9:0]  id_rs;
  logic [63:0] id_rf_data;
  logic        ex_wr, mem_wr, wb_wr;
  logic [4:0]  ex_rd, mem_rd, wb_rd;
  logic [31:0] ex_data, mem_data, wb_data;
  logic        ex_is_load, ex_ready, flush, out_valid, stall;
  logic [63:0] out_ops;
  logic [1:0]  stall_cnt;
  int checks = 0, errors = 0;

  operand_fwd_mux #(.DW(32), .NUM_OPS(2)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_ready(id_ready), .id_rs(id_rs),
    .id_rf_data(id_rf_data), .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd), .ex_data(ex_data),
    .mem_data(mem_data), .wb_data(wb_data), .ex_is_load(ex_is_load),
    .ex_ready(ex_ready), .flush(flush), .out_valid(out_valid), .out_ops(out_ops),
    .stall(stall), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1; id_valid = 1; ex_ready = 1; flush = 0; id_rs = '0; id_rf_data = '0;
    ex_wr = 0; mem_wr = 0; wb_wr = 0; ex_rd = 0; mem_rd = 0; wb_rd = 0;
    ex_data = 0; mem_data = 0; wb_data = 0; ex_is_load = 0;
    tick(); tick();
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_out_ops", out_ops, 0);
    chk("rst_stall_cnt", 64'(stall_cnt), 0);
    chk("rst_id_ready", 64'(id_ready), 0);
    rst = 0; id_valid = 0;
    tick();
    // plain register-file operands
    id_valid = 1; id_rs = {5'd9, 5'd4}; id_rf_data = {32'h9999_0000, 32'h0000_4444};
    #1;
    chk("rf_ready", 64'(id_ready), 1);
    chk("rf_stall", 64'(stall), 0);
    tick();
    chk("rf_valid", 64'(out_valid), 1);
    chk("rf_ops", out_ops, {32'h9999_0000, 32'h0000_4444});
    // rs==0 yields zero even with an ex write to r0
    id_rs = {5'd0, 5'd2}; id_rf_data = {32'h77, 32'h22}; ex_wr = 1; ex_rd = 0; ex_data = 32'hFF;
    #1;
    chk("r0_stall", 64'(stall), 0);
    tick();
    chk("r0_ops", out_ops, {32'h0, 32'h22});
    ex_wr = 0;
    // backpressure holds output and blocks decode
    ex_ready = 0; id_rs = {5'd1, 5'd1}; id_rf_data = {32'hAA, 32'hBB};
    #1;
    chk("bp_ready", 64'(id_ready), 0);
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("bp_ops", out_ops, {32'h0, 32'h22});
      chk("bp_valid", 64'(out_valid), 1);
      chk("bp_ready_hold", 64'(id_ready), 0);
    end
    ex_ready = 1;
    #1;
    chk("bp_release_ready", 64'(id_ready), 1);
    tick();
    chk("bp_release_ops", out_ops, {32'hAA, 32'hBB});
    // load-use hazard inserts a bubble
    id_rs = {5'd0, 5'd3}; id_rf_data = {32'h0, 32'h33};
    ex_wr = 1; ex_is_load = 1; ex_rd = 3; ex_data = 32'hDEAD;
    #1;
    chk("ld_stall", 64'(stall), 1);
    chk("ld_ready", 64'(id_ready), 0);
    tick();
    chk("ld_bubble_valid", 64'(out_valid), 0);
    chk("ld_bubble_ops", out_ops, {32'hAA, 32'hBB});
    chk("ld_cnt1", 64'(stall_cnt), 1);
    ex_wr = 0; ex_is_load = 0; mem_wr = 1; mem_rd = 3; mem_data = 32'hAB;
    #1;
`ifdef OPERAND_FWD_EN
    chk("ld_mem_stall", 64'(stall), 0);
    chk("ld_mem_ready", 64'(id_ready), 1);
    tick();
    chk("ld_mem_valid", 64'(out_valid), 1);
    chk("ld_mem_ops", out_ops, {32'h0, 32'hAB});
    chk("ld_mem_cnt", 64'(stall_cnt), 0);
    mem_wr = 0;
    // EX beats MEM beats WB
    id_rs = {5'd6, 5'd5}; id_rf_data = {32'h66, 32'h55};
    ex_wr = 1; mem_wr = 1; wb_wr = 1; ex_rd = 5; mem_rd = 5; wb_rd = 5;
    ex_data = 32'hE1; mem_data = 32'hE2; wb_data = 32'hE3;
    #1;
    chk("pri_stall", 64'(stall), 0);
    tick();
    chk("pri_ex", out_ops, {32'h66, 32'hE1});
    ex_wr = 0; wb_rd = 6;
    tick();
    chk("pri_mem_wb", out_ops, {32'hE3, 32'hE2});
    id_rs = {5'd0, 5'd5}; mem_data = 32'h11; wb_rd = 5; wb_data = 32'h22;
    tick();
    chk("mem_over_wb", out_ops, {32'h0, 32'h11});
    mem_wr = 0; wb_wr = 0;
`else
    chk("nf_mem_stall", 64'(stall), 1);
    tick();
    chk("nf_mem_cnt", 64'(stall_cnt), 2);
    chk("nf_mem_valid", 64'(out_valid), 0);
    mem_wr = 0; wb_wr = 1; wb_rd = 3; wb_data = 32'hCD;
    #1;
    chk("nf_wb_stall", 64'(stall), 1);
    tick();
    chk("nf_wb_cnt", 64'(stall_cnt), 3);
    wb_wr = 0;
    #1;
    chk("nf_clear_ready", 64'(id_ready), 1);
    tick();
    chk("nf_clear_ops", out_ops, {32'h0, 32'h33});
    chk("nf_clear_cnt", 64'(stall_cnt), 0);
    // non-load EX match still stalls without forwarding
    id_rs = {5'd0, 5'd7}; id_rf_data = {32'h0, 32'h77}; ex_wr = 1; ex_rd = 7;
    #1;
    chk("nf_ex_stall", 64'(stall), 1);
    ex_wr = 0; wb_wr = 1; wb_rd = 7; wb_data = 32'h99;
    for (int k = 1; k <= 4; k++) begin
      #1;
      chk("nf_wb_hold_stall", 64'(stall), 1);
      tick();
      chk("nf_wb_hold_cnt", 64'(stall_cnt), (k > 3) ? 3 : k);
      chk("nf_wb_hold_valid", 64'(out_valid), 0);
    end
    wb_wr = 0;
    tick();
    chk("nf_rf_ops", out_ops, {32'h0, 32'h77});
`endif
    // saturation then flush during stall
    id_rs = {5'd0, 5'd3}; id_rf_data = {32'h0, 32'h3333}; ex_wr = 1; ex_is_load = 1; ex_rd = 3;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk("sat_cnt", 64'(stall_cnt), (k > 3) ? 3 : k);
    end
    flush = 1;
    tick();
    chk("fl_valid", 64'(out_valid), 0);
    chk("fl_cnt", 64'(stall_cnt), 0);
    flush = 0; ex_wr = 0; ex_is_load = 0;
    #1;
    chk("fl_stall", 64'(stall), 0);
    tick();
    chk("fl_accept_valid", 64'(out_valid), 1);
    chk("fl_accept_ops", out_ops, {32'h0, 32'h3333});
    flush = 1;
    tick();
    chk("fl_over_accept", 64'(out_valid), 0);
    // reset while stalled
    flush = 0; ex_wr = 1; ex_is_load = 1;
    tick();
    chk("rs_stall_cnt", 64'(stall_cnt), 1);
    rst = 1;
    #1;
    chk("rs_ready", 64'(id_ready), 0);
    tick();
    chk("rs_cnt", 64'(stall_cnt), 0);
    chk("rs_ops", out_ops, 0);
    rst = 0; ex_wr = 0; ex_is_load = 0; id_valid = 0;
    tick();
    chk("rs_discard", 64'(out_valid), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
